// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared defaults and width helpers for the synchronous FIFO
package fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DEPTH      = 8;

    // Pointers index DEPTH entries; count needs one extra bit to represent DEPTH itself.
    function automatic int fifo_ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int fifo_count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem_dp.sv
// rtl/fifo_mem_dp.sv - DEPTH x DATA_WIDTH register array, sync write, async read
module fifo_mem_dp #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parameterised single-clock FIFO with occupancy flags and error pulses
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2,
    parameter int FWFT       = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   write_en,
    input  logic [DATA_WIDTH-1:0]  data_in,
    input  logic                   read_en,
    output logic [DATA_WIDTH-1:0]  data_out,
    output logic                   empty,
    output logic                   full,
    output logic                   almost_empty,
    output logic                   almost_full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int PW = fifo_ptr_width(DEPTH);
    localparam int CW = fifo_count_width(DEPTH);

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count_q;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  mem_we;

    assign wr_acc = write_en && !full;
    assign rd_acc = read_en && !empty;
    // Reset outranks a same-cycle write so the array is never touched while clearing.
    assign mem_we = wr_acc && !reset;

    fifo_mem_dp #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (PW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (mem_we),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            dout_q    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= write_en && full;
            underflow <= read_en && empty;
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PW'(1);
                dout_q <= rd_data;
            end
            unique case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Flags decode the registered count so they settle one cycle after the accepting edge.
    assign empty        = (count_q == '0);
    assign full         = (count_q == CW'(DEPTH));
    assign almost_full  = (count_q >= CW'(AF_THRESH));
    assign almost_empty = (count_q <= CW'(AE_THRESH));
    assign count        = count_q;

    assign data_out = (FWFT != 0) ? rd_data : dout_q;

endmodule

// File: doc/sync_fifo_param.md
SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 8, number of entries (power of 2, >=2).
REQ-003 SHALL have parameter AF_THRESH, default DEPTH-2, almost_full level (1..DEPTH).
REQ-004 SHALL have parameter AE_THRESH, default 2, almost_empty level (0..DEPTH-1).
REQ-005 SHALL have parameter FWFT, default 0, read mode (0 = registered read, 1 = first-word-fall-through).
REQ-006 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port write_en  input  1  write request.
REQ-009 SHALL have port data_in  input  DATA_WIDTH  write data.
REQ-010 SHALL have port read_en  input  1  read request.
REQ-011 SHALL have port data_out  output  DATA_WIDTH  read data.
REQ-012 SHALL have ports empty, full, almost_empty, almost_full  output  1 each  occupancy flags.
REQ-013 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy, range 0..DEPTH.
REQ-014 SHALL have ports overflow, underflow  output  1 each  rejected-request pulses.

Function
REQ-015 SHALL accept a write (wr_acc) when write_en=1 and full=0, storing data_in at the write pointer.
REQ-016 SHALL accept a read (rd_acc) when read_en=1 and empty=0, advancing the read pointer.
REQ-017 SHALL keep read and write pointers $clog2(DEPTH) bits wide, incrementing mod DEPTH (natural wrap DEPTH-1 -> 0).
REQ-018 SHALL update count: +1 on wr_acc only, -1 on rd_acc only, unchanged when both or neither are accepted.
REQ-019 SHALL, when empty, reject a simultaneous read and accept the write; there is no write-to-read bypass.
REQ-020 SHALL, when full, reject a simultaneous write and accept the read; count becomes DEPTH-1.
REQ-021 SHALL decode flags from the count register: empty = (count==0); full = (count==DEPTH); almost_full = (count>=AF_THRESH); almost_empty = (count<=AE_THRESH).
REQ-022 SHALL, with FWFT=0, register data_out with the head word one cycle after rd_acc, and hold data_out otherwise.
REQ-023 SHALL, with FWFT=1, drive data_out combinationally with the head word; data_out is valid while empty=0 and don't-care while empty=1.
REQ-024 SHALL, with FWFT=1, make the first write into an empty FIFO visible on data_out in the cycle after the write edge.
REQ-025 SHALL pulse overflow high for exactly one cycle, in the cycle after an edge where write_en=1 and full=1.
REQ-026 SHALL pulse underflow high for exactly one cycle, in the cycle after an edge where read_en=1 and empty=1.
REQ-027 SHALL leave memory, pointers and count unchanged on any rejected request.

Reset
REQ-028 SHALL, while reset=1 at a rising edge, clear both pointers and count to 0.
REQ-029 SHALL set empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0 and registered data_out=0 one cycle after that reset edge.
REQ-030 SHALL give reset priority over write_en and read_en in the same cycle, discarding all stored data, including mid-burst.
REQ-031 SHALL NOT require memory array contents to be reset.

Structure
REQ-032 SHALL place shared constants (default DATA_WIDTH, default DEPTH, pointer/count width function) in shared package fifo_pkg.
REQ-033 SHALL instantiate one sub-module, fifo_mem_dp: a DEPTH x DATA_WIDTH register array with a synchronous write port and an asynchronous read port.
REQ-034 SHALL keep pointer, count, flag and pulse logic in sync_fifo_param.

Verification (DEPTH=8, DATA_WIDTH=8, AF_THRESH=6, AE_THRESH=2 unless stated)
REQ-035 SHALL cover fill/drain: write 12,34,56,78,9A,BC,DE,FF -> full=1, count=8; 8 reads -> same order out, empty=1.
REQ-036 SHALL cover flags: count 2 -> almost_empty=1; count 3 -> almost_empty=0; count 6 -> almost_full=1; count 5 -> almost_full=0.
REQ-037 SHALL cover errors: write AA when full -> overflow pulses one cycle, contents unchanged; read when empty -> underflow pulses one cycle.
REQ-038 SHALL cover simultaneous access: read+write at count=4 -> count stays 4; at full -> count 7, write dropped; at empty -> count 1, no underflow data.
REQ-039 SHALL cover wrap: 20 interleaved write/read cycles with incrementing data -> data in order, pointers wrap cleanly.
REQ-040 SHALL cover FWFT and reset: FWFT=1, write 5A to empty -> data_out=5A next cycle without read; reset mid-burst at count=5 -> count=0, empty=1.
